vga_timing_receiver: RTL and testbench

//  Receive side of our VGA video interface. Takes a sync/RGB stream in the same iCLK

---
 rtl/vga_timing_receiver_if.sv | 17 +
 rtl/vga_timing_receiver.sv | 222 ++++++++++++++++++++++
 tb/tb_vga_timing_receiver.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_receiver_if.sv
// Sync/RGB video stream between a VGA source and a receiver.
// Master drives the stream, slave observes it.
interface vga_timing_receiver_if;
  logic       h_sync;
  logic       v_sync;
  logic [9:0] r;
  logic [9:0] g;
  logic [9:0] b;

  modport master (
    output h_sync, v_sync, r, g, b
  );

  modport slave (
    input h_sync, v_sync, r, g, b
  );
endinterface

// File: rtl/vga_timing_receiver.sv
// VGA receive side: recovers H/V timing, locks, regenerates coordinates.
// Optional per-frame pixel checksum: define VGA_RX_CHECKSUM_EN.
module vga_timing_receiver #(
  parameter int H_BACK      = 144,
  parameter int H_ACT       = 640,
  parameter int H_TOTAL     = 800,
  parameter int V_BACK      = 35,
  parameter int V_ACT       = 480,
  parameter int V_TOTAL     = 525,
  parameter int H_TOL       = 2,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                  iCLK,
  input  logic                  iRST_N,
  vga_timing_receiver_if.slave  vga,
  output logic [9:0]            oCoord_X,
  output logic [9:0]            oCoord_Y,
  output logic                  oPix_Valid,
  output logic [9:0]            oR,
  output logic [9:0]            oG,
  output logic [9:0]            oB,
  output logic [10:0]           oLine_Len,
  output logic [10:0]           oFrame_Lines,
  output logic                  oLocked,
  output logic                  oErr,
  output logic [31:0]           oFrame_Sum,
  output logic                  oSum_Valid
);

  localparam logic [10:0] HB   = 11'(H_BACK);
  localparam logic [10:0] HE   = 11'(H_BACK + H_ACT);
  localparam logic [10:0] VB   = 11'(V_BACK);
  localparam logic [10:0] VE   = 11'(V_BACK + V_ACT);
  localparam logic [10:0] HMIN = 11'(H_TOTAL - H_TOL);
  localparam logic [10:0] HMAX = 11'(H_TOTAL + H_TOL);
  localparam logic [10:0] VT   = 11'(V_TOTAL);
  localparam logic [10:0] CMAX = 11'h7FF;
  localparam logic [3:0]  LF   = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH,
    ACQUIRE,
    LOCKED
  } state_t;

  state_t      state;
  logic [3:0]  good_cnt;
  logic        hs_q, hs_d, vs_q, vs_d;
  logic [9:0]  r_q, g_q, b_q;
  logic [10:0] h_cnt, v_cnt;
  logic        v_pend;
  logic        lines_ok;

  logic        h_edge, v_edge, frame_end;
  logic        h_lost;
  logic [10:0] line_len, frame_lines;
  logic        line_ok, frame_ok;
  logic        active;

  assign h_edge      = hs_d & ~hs_q;
  assign v_edge      = vs_d & ~vs_q;
  assign frame_end   = h_edge & (v_pend | v_edge);
  assign h_lost      = (h_cnt == CMAX) & ~h_edge;
  assign line_len    = h_cnt + 11'd1;
  assign frame_lines = v_cnt + 11'd1;
  assign line_ok     = (line_len >= HMIN) &&
                       (line_len <= HMAX);
  assign frame_ok    = lines_ok & line_ok &
                       (frame_lines == VT);
  assign active      = oLocked &&
                       (h_cnt >= HB) && (h_cnt < HE) &&
                       (v_cnt >= VB) && (v_cnt < VE);

  // Stage 1: register inputs, keep previous sync for edges
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      hs_q <= 1'b1;
      hs_d <= 1'b1;
      vs_q <= 1'b1;
      vs_d <= 1'b1;
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
    end else begin
      hs_q <= vga.h_sync;
      hs_d <= hs_q;
      vs_q <= vga.v_sync;
      vs_d <= vs_q;
      r_q  <= vga.r;
      g_q  <= vga.g;
      b_q  <= vga.b;
    end
  end

  // Line/frame measurement counters
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      h_cnt        <= '0;
      v_cnt        <= '0;
      v_pend       <= 1'b0;
      lines_ok     <= 1'b0;
      oLine_Len    <= '0;
      oFrame_Lines <= '0;
    end else if (h_edge) begin
      h_cnt     <= '0;
      oLine_Len <= line_len;
      if (frame_end) begin
        oFrame_Lines <= frame_lines;
        v_cnt        <= '0;
        v_pend       <= 1'b0;
        lines_ok     <= 1'b1;
      end else begin
        lines_ok <= lines_ok & line_ok;
        if (v_cnt != CMAX)
          v_cnt <= v_cnt + 11'd1;
      end
    end else begin
      if (h_cnt != CMAX)
        h_cnt <= h_cnt + 11'd1;
      if (v_edge)
        v_pend <= 1'b1;
    end
  end

  // Lock FSM with registered lock/error outputs
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state    <= SEARCH;
      good_cnt <= '0;
      oLocked  <= 1'b0;
      oErr     <= 1'b0;
    end else begin
      oErr <= 1'b0;
      if (h_lost) begin
        state    <= SEARCH;
        good_cnt <= '0;
        oLocked  <= 1'b0;
      end else begin
        unique case (state)
          SEARCH: begin
            if (frame_end) begin
              state    <= ACQUIRE;
              good_cnt <= '0;
            end
          end
          ACQUIRE: begin
            if (frame_end) begin
              if (!frame_ok) begin
                good_cnt <= '0;
              end else if (good_cnt + 4'd1 == LF) begin
                state    <= LOCKED;
                good_cnt <= '0;
                oLocked  <= 1'b1;
              end else begin
                good_cnt <= good_cnt + 4'd1;
              end
            end
          end
          LOCKED: begin
            if (h_edge &&
                (!line_ok || (frame_end && !frame_ok))) begin
              state    <= ACQUIRE;
              good_cnt <= '0;
              oLocked  <= 1'b0;
              oErr     <= 1'b1;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

  // Pixel output stage: blank everything outside the active area
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oPix_Valid <= 1'b0;
      oCoord_X   <= '0;
      oCoord_Y   <= '0;
      oR         <= '0;
      oG         <= '0;
      oB         <= '0;
    end else begin
      oPix_Valid <= active;
      oCoord_X   <= active ? 10'(h_cnt - HB) : '0;
      oCoord_Y   <= active ? 10'(v_cnt - VB) : '0;
      oR         <= active ? r_q : '0;
      oG         <= active ? g_q : '0;
      oB         <= active ? b_q : '0;
    end
  end

`ifdef VGA_RX_CHECKSUM_EN
  logic [31:0] sum32;
  logic [31:0] pix_sum;

  assign pix_sum = 32'(oR) + 32'(oG) + 32'(oB);

  // Accumulate output pixels, publish and restart per frame
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sum32      <= '0;
      oFrame_Sum <= '0;
      oSum_Valid <= 1'b0;
    end else begin
      oSum_Valid <= frame_end;
      if (frame_end) begin
        oFrame_Sum <= sum32;
        sum32      <= '0;
      end else if (!oLocked) begin
        sum32 <= '0;
      end else if (oPix_Valid) begin
        sum32 <= sum32 + pix_sum;
      end
    end
  end
`else
  assign oFrame_Sum = '0;
  assign oSum_Valid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Directed bench for vga_timing_receiver on a reduced 64x14 mode.
// Line vectors in a table, lock/reset/idle sequences hand-written.
module tb_vga_timing_receiver;

  localparam int HB  = 16;
  localparam int HA  = 40;
  localparam int HT  = 64;
  localparam int VB  = 3;
  localparam int VA  = 8;
  localparam int VT  = 14;
  localparam int HSW = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  cx, cy, o_r, o_g, o_b;
  logic        pv, locked, err, sv;
  logic [10:0] llen, flines;
  logic [31:0] fsum;

  vga_timing_receiver_if vif ();

  vga_timing_receiver #(
    .H_BACK(HB), .H_ACT(HA), .H_TOTAL(HT),
    .V_BACK(VB), .V_ACT(VA), .V_TOTAL(VT),
    .H_TOL(2), .LOCK_FRAMES(2)
  ) dut (
    .iCLK(clk),
    .iRST_N(rst_n),
    .vga(vif),
    .oCoord_X(cx),
    .oCoord_Y(cy),
    .oPix_Valid(pv),
    .oR(o_r),
    .oG(o_g),
    .oB(o_b),
    .oLine_Len(llen),
    .oFrame_Lines(flines),
    .oLocked(locked),
    .oErr(err),
    .oFrame_Sum(fsum),
    .oSum_Valid(sv)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int line_idx = 0;
  bit chk_pix  = 0;
  bit pix_mode = 0;
  int err_cyc  = 0;
  int overlap  = 0;
  int sum_pulses = 0;
  int sum_nz = 0;
  logic [31:0] sum_last = '0;

  typedef struct {
    int len;
    int exp_len;
    int exp_err;
    int exp_lock;
  } vec_t;

  vec_t tv [6];

  // Observe pulse-type outputs every cycle
  always @(negedge clk) begin
    if (err) err_cyc++;
    if (err && locked) overlap++;
    if (sv) begin
      sum_pulses++;
      sum_last = fsum;
    end
    if (fsum != 0) sum_nz++;
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'(pv), 0);
    check({tag, "_locked"}, 32'(locked), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_linelen"}, 32'(llen), 0);
    check({tag, "_frlines"}, 32'(flines), 0);
    check({tag, "_coord"}, 32'(cx | cy), 0);
    check({tag, "_rgb"}, 32'(o_r | o_g | o_b), 0);
    check({tag, "_sum"}, fsum | 32'(sv), 0);
  endtask

  task automatic send_line(input int len);
    for (int j = 0; j < len; j++) begin
      @(negedge clk);
      if (chk_pix) begin
        if (line_idx == VB && j == 18)
          check("pre_active", 32'(pv), 0);
        if (line_idx == VB && j == 19) begin
          check("p00_valid", 32'(pv), 1);
          check("p00_x", 32'(cx), 0);
          check("p00_y", 32'(cy), 0);
          check("p00_r", 32'(o_r), 32'h3FF);
          check("p00_g", 32'(o_g), 3);
          check("p00_b", 32'(o_b), 32'h155);
        end
        if (line_idx == VB + VA - 1 && j == 58) begin
          check("plast_valid", 32'(pv), 1);
          check("plast_x", 32'(cx), 39);
          check("plast_y", 32'(cy), 7);
          check("plast_r", 32'(o_r), 56);
        end
        if (line_idx == VB + VA - 1 && j == 59) begin
          check("post_valid", 32'(pv), 0);
          check("post_r", 32'(o_r), 0);
          check("post_x", 32'(cx), 0);
        end
        if (line_idx == VB + VA && j == 19)
          check("below_valid", 32'(pv), 0);
      end
      vif.h_sync = (j >= HSW);
      vif.v_sync = (line_idx >= 2);
      if (pix_mode) begin
        vif.r = 10'd1;
        vif.g = 10'd1;
        vif.b = 10'd1;
      end else begin
        vif.r = (line_idx == VB && j == 17) ?
                10'h3FF : 10'(j);
        vif.g = 10'(line_idx);
        vif.b = 10'h155;
      end
    end
    line_idx = (line_idx + 1) % VT;
  endtask

  task automatic send_frame();
    for (int l = 0; l < VT; l++)
      send_line(HT);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      vif.h_sync = 1'b1;
      vif.v_sync = 1'b1;
    end
  endtask

  // From ACQUIRE after an error: bad frame, then 2 good frames
  task automatic relock(input string tag);
    while (line_idx != 0)
      send_line(HT);
    send_frame();
    send_frame();
    check({tag, "_prelock"}, 32'(locked), 0);
    send_line(HT);
    check({tag, "_lock"}, 32'(locked), 1);
  endtask

  // From SEARCH: lock on the 3rd frame_end
  task automatic cold_lock(input string tag);
    line_idx = 0;
    send_frame();
    send_frame();
    check({tag, "_prelock"}, 32'(locked), 0);
    send_line(HT);
    check({tag, "_lock"}, 32'(locked), 1);
  endtask

  initial begin
    int e0;
    int p0;
    tv[0] = '{HT,     HT,     0, 1};
    tv[1] = '{HT + 1, HT + 1, 0, 1};
    tv[2] = '{HT - 1, HT - 1, 0, 1};
    tv[3] = '{HT + 2, HT + 2, 0, 1};
    tv[4] = '{HT - 2, HT - 2, 0, 1};
    tv[5] = '{HT + 3, HT + 3, 1, 0};

    rst_n = 1'b0;
    vif.h_sync = 1'b1;
    vif.v_sync = 1'b1;
    vif.r = '0;
    vif.g = '0;
    vif.b = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    line_idx = 0;
    send_frame();
    send_frame();
    check("nom_prelock", 32'(locked), 0);
    check("nom_linelen", 32'(llen), HT);
    check("nom_frlines", 32'(flines), VT);
    chk_pix = 1;
    send_frame();
    chk_pix = 0;
    check("nom_locked", 32'(locked), 1);
    check("nom_no_err", 32'(err_cyc), 0);

    for (int i = 0; i < 6; i++) begin
      e0 = err_cyc;
      send_line(tv[i].len);
      send_line(HT);
      check($sformatf("vec%0d_len", i),
            32'(llen), 32'(tv[i].exp_len));
      check($sformatf("vec%0d_err", i),
            32'(err_cyc - e0), 32'(tv[i].exp_err));
      check($sformatf("vec%0d_lock", i),
            32'(locked), 32'(tv[i].exp_lock));
    end
    relock("tol");

    e0 = err_cyc;
    send_line(HT - 10);
    send_line(HT);
    check("short_len", 32'(llen), HT - 10);
    check("short_err_pulse", 32'(err_cyc - e0), 1);
    check("short_unlock", 32'(locked), 0);
    relock("short");

    e0 = err_cyc;
    idle(2100);
    check("idle_unlock", 32'(locked), 0);
    check("idle_no_err", 32'(err_cyc - e0), 0);
    line_idx = 0;
    send_frame();
    send_frame();
    check("idle_prelock", 32'(locked), 0);
    pix_mode = 1;
    send_frame();
    check("sum_locked", 32'(locked), 1);
    p0 = sum_pulses;
    send_line(HT);
    pix_mode = 0;
`ifdef VGA_RX_CHECKSUM_EN
    check("sum_pulse", 32'(sum_pulses - p0), 1);
    check("sum_value", sum_last, 32'(HA * VA * 3));
`else
    check("sum_no_pulse", 32'(sum_pulses), 0);
    check("sum_zero", 32'(sum_nz), 0);
`endif

    while (line_idx != 5)
      send_line(HT);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cold_lock("post_rst");

    check("err_lock_overlap", 32'(overlap), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
